// File: rtl/sm_keypad_scanner_pkg.sv
// +-----------------------------------------------------------------+
// | sm_keypad_scanner_pkg: keypad geometry and key-code helpers      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package sm_keypad_scanner_pkg;

  localparam int GPIO_SIZE   = 8;
  localparam int KEYPAD_ROWS = 4;
  localparam int KEYPAD_COLS = 4;
  localparam logic [4:0] KEY_NONE = 5'h10;

  typedef logic [4:0] cand_t;

  // Frame bit b = col*4 + row; reported code = row*4 + col.
  function automatic logic [3:0] bitToCode(input logic [3:0] b);
    return {b[1:0], b[3:2]};
  endfunction

  function automatic cand_t lowestCand(input logic [KEYPAD_ROWS*KEYPAD_COLS-1:0] frame);
    cand_t res;
    res = KEY_NONE;
    for (int i = KEYPAD_ROWS*KEYPAD_COLS-1; i >= 0; i--) begin
      if (frame[i]) res = {1'b0, bitToCode(4'(i))};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_keypad_scanner_debouncer.sv
// +-----------------------------------------------------------------+
// | sm_debouncer: two-flop synchronizer for asynchronous inputs      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module sm_debouncer #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] r_meta;
  logic [SIZE-1:0] r_sync;

  // Resets to all-ones: the pads idle high through their pull-ups.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/sm_keypad_scanner.sv
// +-----------------------------------------------------------------+
// | sm_keypad_scanner: 4x4 matrix keypad scanner with frame debounce |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module sm_keypad_scanner
  import sm_keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_en,
  input  logic [KEYPAD_ROWS-1:0] row_n,
  output logic [KEYPAD_COLS-1:0] col_n,
  output logic [3:0]             key_code,
  output logic                   key_pressed,
  output logic                   key_strobe
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STABLE_W = $clog2(DEBOUNCE_FRAMES) + 1;
  localparam int FRAME_W  = KEYPAD_ROWS * KEYPAD_COLS;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_EVAL   = 2'd2;

  localparam logic [SETTLE_W-1:0] c_settleLast = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [STABLE_W-1:0] c_stableLast = STABLE_W'(DEBOUNCE_FRAMES - 1);

  logic [1:0]             r_state;
  logic [1:0]             r_colIdx;
  logic [SETTLE_W-1:0]    r_settleCnt;
  logic [FRAME_W-1:0]     r_frame;
  cand_t                  r_lastCand;
  cand_t                  r_reported;
  logic [STABLE_W-1:0]    r_stableCnt;
  logic [3:0]             r_keyCode;
  logic                   r_keyPressed;
  logic                   r_keyStrobe;

  logic [KEYPAD_ROWS-1:0] w_rowsN;
  logic [KEYPAD_ROWS-1:0] w_rows;
  cand_t                  w_cand;
  logic [STABLE_W-1:0]    w_nextStable;
  logic                   w_report;

  sm_debouncer #(.SIZE(KEYPAD_ROWS)) u_rowSync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (w_rowsN)
  );

  assign w_rows = ~w_rowsN;

  always_comb begin
    w_cand = lowestCand(r_frame);
    if (w_cand != r_lastCand)
      w_nextStable = '0;
    else if (r_stableCnt == c_stableLast)
      w_nextStable = r_stableCnt;
    else
      w_nextStable = r_stableCnt + 1'b1;
    w_report = (w_nextStable == c_stableLast) && (w_cand != r_reported);
  end

  assign col_n = (scan_en && (r_state != ST_EVAL)) ? ~(4'b0001 << r_colIdx) : 4'b1111;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_SETTLE;
      r_colIdx     <= '0;
      r_settleCnt  <= '0;
      r_frame      <= '0;
      r_lastCand   <= KEY_NONE;
      r_reported   <= KEY_NONE;
      r_stableCnt  <= '0;
      r_keyCode    <= '0;
      r_keyPressed <= 1'b0;
      r_keyStrobe  <= 1'b0;
    end else begin
      r_keyStrobe <= 1'b0;
      if (!scan_en) begin
        // Column is released while frozen, so its slot restarts settling.
        if (r_state != ST_EVAL) begin
          r_state     <= ST_SETTLE;
          r_settleCnt <= '0;
        end
      end else begin
        case (r_state)
          ST_SETTLE: begin
            if (r_settleCnt == c_settleLast) begin
              r_settleCnt <= '0;
              r_state     <= ST_SAMPLE;
            end else begin
              r_settleCnt <= r_settleCnt + 1'b1;
            end
          end
          ST_SAMPLE: begin
            r_frame[{r_colIdx, 2'b00} +: KEYPAD_ROWS] <= w_rows;
            if (r_colIdx == 2'd3) begin
              r_state <= ST_EVAL;
            end else begin
              r_colIdx <= r_colIdx + 1'b1;
              r_state  <= ST_SETTLE;
            end
          end
          ST_EVAL: begin
            r_frame     <= '0;
            r_colIdx    <= '0;
            r_state     <= ST_SETTLE;
            r_lastCand  <= w_cand;
            r_stableCnt <= w_nextStable;
            if (w_report) begin
              r_reported <= w_cand;
              if (w_cand[4]) begin
                r_keyPressed <= 1'b0;
              end else begin
                r_keyCode    <= w_cand[3:0];
                r_keyPressed <= 1'b1;
                r_keyStrobe  <= 1'b1;
              end
            end
          end
          default: r_state <= ST_SETTLE;
        endcase
      end
    end
  end

  assign key_code    = r_keyCode;
  assign key_pressed = r_keyPressed;
  assign key_strobe  = r_keyStrobe;

endmodule

`default_nettype wire

// File: tb/tb_sm_keypad_scanner.sv
// +-----------------------------------------------------------------+
// | tb_sm_keypad_scanner: scoreboard bench with a keypad pad model   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_sm_keypad_scanner;

  localparam int DEB   = 4;
  localparam int FRAME = 17;
  localparam int NONE  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_en = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       key_strobe;
  logic [15:0] keys = '0;   // bit index = key code = row*4 + col

  int tests = 0;
  int fails = 0;
  int expQ[$];
  int lastCand, runLen, reported;
  int mPressed;

  sm_keypad_scanner #(.SETTLE_CYCLES(3), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .key_strobe  (key_strobe)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner is the first pressed key scanning column 0..3, rows 0..3 within each.
  function automatic int frameCand(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4 + c]) return r*4 + c;
    return NONE;
  endfunction

  task automatic modelReset();
    lastCand = NONE;
    runLen   = 1;
    reported = NONE;
    mPressed = 0;
  endtask

  // A key is reported once DEB consecutive frames agree on it.
  task automatic modelFrame(input int cand);
    if (cand == lastCand) runLen++;
    else begin
      lastCand = cand;
      runLen   = 1;
    end
    if (runLen >= DEB && cand != reported) begin
      reported = cand;
      if (cand != NONE) begin
        expQ.push_back(cand);
        mPressed = 1;
      end else begin
        mPressed = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && key_strobe) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL strobe_unexpected: got code %0d, expected no strobe (t=%0t)", key_code, $time);
      end else begin
        check("strobe_code", key_code, expQ.pop_front());
      end
    end
  end

  // Entered on the negedge inside an EVAL cycle; leaves on the EVAL cycle n frames later.
  task automatic runSegment(input logic [15:0] m, input int n);
    keys = m;
    @(negedge clk);
    check("pressed_level", key_pressed, mPressed);
    for (int i = 0; i < n; i++) modelFrame(frameCand(m));
    repeat (FRAME*n - 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] expCol;
    logic [15:0] m;
    int a, b;
    modelReset();
    repeat (3) @(negedge clk);
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_pressed", key_pressed, 0);
    check("rst_strobe", key_strobe, 0);
    rst = 1'b0;

    // Idle scan: two full frames of column sequencing.
    for (int k = 0; k < 2*FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if ((k % FRAME) == FRAME-1) expCol = 4'b1111;
      else expCol = ~(4'b0001 << ((k % FRAME) / 4));
      check("idle_col_n", col_n, expCol);
    end
    modelFrame(NONE);
    modelFrame(NONE);

    runSegment(16'h0001 << 9, 5);
    runSegment(16'h0000, 5);
    runSegment((16'h0001 << 6) | (16'h0001 << 13), 5);
    runSegment(16'h0001 << 13, 5);
    runSegment(16'h0000, 5);
    for (int i = 0; i < 6; i++) runSegment((i % 2 == 0) ? (16'h0001 << 9) : 16'h0000, 1);
    runSegment(16'h0001 << 9, 5);

    for (int s = 0; s < 20; s++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       m = '0;
        1, 2:    m = 16'h0001 << a;
        default: m = (16'h0001 << a) | (16'h0001 << b);
      endcase
      runSegment(m, $urandom_range(1, 6));
    end
    runSegment(16'h0000, 5);

    // Reset three frames into debouncing key 9.
    runSegment(16'h0001 << 9, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_col_n", col_n, 4'b1110);
    check("midrst_key_code", key_code, 0);
    check("midrst_pressed", key_pressed, 0);
    check("midrst_strobe", key_strobe, 0);
    rst = 1'b0;
    modelReset();
    for (int f = 0; f < 5; f++) modelFrame(9);
    repeat (FRAME-1 + FRAME*5) @(negedge clk);
    @(negedge clk);
    check("midrst_pressed_after", key_pressed, 1);
    check("midrst_code_after", key_code, 9);
    check("midrst_queue_drained", expQ.size(), 0);

    // Freeze mid-slot on column 2.
    rst = 1'b1;
    keys = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    check("freeze_pre_col_n", col_n, 4'b1011);
    scan_en = 1'b0;
    #1;
    check("freeze_col_n", col_n, 4'b1111);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 0) check("freeze_hold_col_n", col_n, 4'b1111);
    end
    scan_en = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      check("resume_col2_slot", col_n, 4'b1011);
    end
    @(negedge clk);
    check("resume_col3", col_n, 4'b0111);
    check("resume_pressed", key_pressed, 0);

    repeat (FRAME) @(negedge clk);
    check("final_queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
